// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: pooling FSM state encoding and the
// output-dimension helper used by both the conv and pooling stages.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } pool_state_e;

  function automatic int unsigned out_dim(input int unsigned in_dim,
                                          input int unsigned win,
                                          input int unsigned stride);
    return (in_dim - win) / stride + 1;
  endfunction

  // Counter width that never collapses to zero bits for degenerate sizes.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_window_addr.sv
// Channel/row/col/kernel-element counters for the max-pool scan and the
// flat tensor address of the element currently being examined.
module pool_window_addr
  import cnn_pkg::*;
#(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned IN_HEIGHT   = 4,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned POOL_SIZE   = 2,
  parameter int unsigned POOL_STRIDE = 2,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last_elem,
  output logic              last_window
);

  localparam int unsigned OUT_H = out_dim(IN_HEIGHT, POOL_SIZE, POOL_STRIDE);
  localparam int unsigned OUT_W = out_dim(IN_WIDTH, POOL_SIZE, POOL_STRIDE);
  localparam int unsigned CH_W  = cnt_w(CHANNELS);
  localparam int unsigned ROW_W = cnt_w(OUT_H);
  localparam int unsigned COL_W = cnt_w(OUT_W);
  localparam int unsigned K_W   = cnt_w(POOL_SIZE);

  logic [CH_W-1:0]  ch_q, ch_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [K_W-1:0]   kh_q, kh_d;
  logic [K_W-1:0]   kw_q, kw_d;

  logic last_kw, last_kh, last_col, last_row, last_ch;

  assign last_kw  = (kw_q == K_W'(POOL_SIZE - 1));
  assign last_kh  = (kh_q == K_W'(POOL_SIZE - 1));
  assign last_col = (col_q == COL_W'(OUT_W - 1));
  assign last_row = (row_q == ROW_W'(OUT_H - 1));
  assign last_ch  = (ch_q == CH_W'(CHANNELS - 1));

  assign last_elem   = last_kw && last_kh;
  assign last_window = last_col && last_row && last_ch;

  // k is kept as separate kh/kw counters so no divide by P is needed.
  always_comb begin
    ch_d  = ch_q;
    row_d = row_q;
    col_d = col_q;
    kh_d  = kh_q;
    kw_d  = kw_q;
    if (clear) begin
      ch_d  = '0;
      row_d = '0;
      col_d = '0;
      kh_d  = '0;
      kw_d  = '0;
    end else if (step) begin
      if (!last_kw) begin
        kw_d = kw_q + K_W'(1);
      end else begin
        kw_d = '0;
        if (!last_kh) begin
          kh_d = kh_q + K_W'(1);
        end else begin
          kh_d = '0;
          col_d = last_col ? '0 : col_q + COL_W'(1);
          if (last_col) begin
            row_d = last_row ? '0 : row_q + ROW_W'(1);
            if (last_row) begin
              ch_d = last_ch ? '0 : ch_q + CH_W'(1);
            end
          end
        end
      end
    end
  end

  assign addr = ADDR_W'(32'(ch_q) * IN_HEIGHT * IN_WIDTH
                      + (32'(row_q) * POOL_STRIDE + 32'(kh_q)) * IN_WIDTH
                      + 32'(col_q) * POOL_STRIDE + 32'(kw_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      row_q <= '0;
      col_q <= '0;
      kh_q  <= '0;
      kw_q  <= '0;
    end else begin
      ch_q  <= ch_d;
      row_q <= row_d;
      col_q <= col_d;
      kh_q  <= kh_d;
      kw_q  <= kw_d;
    end
  end

endmodule

// File: rtl/maxpool_stream.sv
// Sequential max-pooling stage: captures one flattened tensor, scans each
// window one element per cycle and streams pooled words out.
// Optional macro MAXPOOL_RELU_EN fuses ReLU by starting the running max at 0.
module maxpool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned CHANNELS    = 1,
  parameter int unsigned IN_HEIGHT   = 4,
  parameter int unsigned IN_WIDTH    = 4,
  parameter int unsigned POOL_SIZE   = 2,
  parameter int unsigned POOL_STRIDE = 2,
  parameter int unsigned DATA_WIDTH  = 32
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] in_tensor_flat,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [DATA_WIDTH-1:0]                         out_data,
  output logic                                          out_last,
  output logic                                          busy
);

  localparam int unsigned N_IN   = CHANNELS * IN_HEIGHT * IN_WIDTH;
  localparam int unsigned ADDR_W = cnt_w(N_IN);

`ifdef MAXPOOL_RELU_EN
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = '0;
`else
  localparam logic signed [DATA_WIDTH-1:0] MAX_INIT = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  pool_state_e state_q, state_d;
  logic [N_IN*DATA_WIDTH-1:0]    tensor_q, tensor_d;
  logic signed [DATA_WIDTH-1:0]  max_q, max_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;

  logic                          clear, step;
  logic [ADDR_W-1:0]             addr;
  logic                          last_elem, last_window;
  logic signed [DATA_WIDTH-1:0]  elem, cand;

  pool_window_addr #(
    .CHANNELS   (CHANNELS),
    .IN_HEIGHT  (IN_HEIGHT),
    .IN_WIDTH   (IN_WIDTH),
    .POOL_SIZE  (POOL_SIZE),
    .POOL_STRIDE(POOL_STRIDE),
    .ADDR_W     (ADDR_W)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .step       (step),
    .addr       (addr),
    .last_elem  (last_elem),
    .last_window(last_window)
  );

  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (addr == ADDR_W'(i)) elem = tensor_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign cand = (elem > max_q) ? elem : max_q;

  always_comb begin
    state_d    = state_q;
    tensor_d   = tensor_q;
    max_d      = max_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    clear      = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          tensor_d = in_tensor_flat;
          clear    = 1'b1;
          max_d    = MAX_INIT;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        max_d = cand;
        if (last_elem) begin
          out_data_d = cand;
          out_last_d = last_window;
          state_d    = EMIT;
        end else begin
          step = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            step    = 1'b1;
            max_d   = MAX_INIT;
            state_d = SCAN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tensor_q   <= '0;
      max_q      <= MAX_INIT;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tensor_q   <= tensor_d;
      max_q      <= max_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// Directed self-checking bench for maxpool_stream: a 1-channel and a
// 2-channel instance, 4x4 input, 2x2 pool, stride 2.
module tb_maxpool_stream;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               in_valid1, in_ready1, out_valid1, out_ready1, out_last1, busy1;
  logic [16*DW-1:0]   tensor1;
  logic [DW-1:0]      out_data1;
  logic               in_valid2, in_ready2, out_valid2, out_ready2, out_last2, busy2;
  logic [32*DW-1:0]   tensor2;
  logic [DW-1:0]      out_data2;

  maxpool_stream #(
    .CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
    .POOL_SIZE(2), .POOL_STRIDE(2), .DATA_WIDTH(DW)
  ) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_tensor_flat(tensor1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_last(out_last1), .busy(busy1)
  );

  maxpool_stream #(
    .CHANNELS(2), .IN_HEIGHT(4), .IN_WIDTH(4),
    .POOL_SIZE(2), .POOL_STRIDE(2), .DATA_WIDTH(DW)
  ) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_tensor_flat(tensor2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .out_last(out_last2), .busy(busy2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] got_data [0:7];
  logic          got_last [0:7];
  int            got_cyc  [0:7];
  int            got_n;

  function automatic logic [32*DW-1:0] ramp(input int base, input int mult);
    logic [32*DW-1:0] t;
    t = '0;
    for (int i = 0; i < 32; i++) t[i*DW +: DW] = DW'(base + mult * i);
    return t;
  endfunction

  task automatic send(input int sel, input logic [32*DW-1:0] t);
    int w;
    w = 0;
    while (((sel == 1) ? in_ready1 : in_ready2) !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 100) begin
      n_bad++;
      $display("FAIL send_ready dut%0d: in_ready stayed low, expected 1", sel);
    end
    if (sel == 1) begin
      in_valid1 = 1'b1;
      tensor1   = t[16*DW-1:0];
    end else begin
      in_valid2 = 1'b1;
      tensor2   = t;
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    in_valid2 = 1'b0;
  endtask

  // Records handshaken outputs; cycle 0 is the falling edge after capture.
  task automatic collect(input int sel, input int n);
    got_n = 0;
    for (int cyc = 0; cyc < 400 && got_n < n; cyc++) begin
      if (sel == 1 ? (out_valid1 && out_ready1) : (out_valid2 && out_ready2)) begin
        got_data[got_n] = (sel == 1) ? out_data1 : out_data2;
        got_last[got_n] = (sel == 1) ? out_last1 : out_last2;
        got_cyc[got_n]  = cyc;
        got_n++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (got_n != n) begin
      n_bad++;
      $display("FAIL collect_count dut%0d: got %0d outputs, expected %0d", sel, got_n, n);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({in_ready1, out_valid1, out_last1, busy1} !== 4'b1000 || out_data1 !== '0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b vld=%b last=%b busy=%b data=%0d, expected 1 0 0 0 0",
               in_ready1, out_valid1, out_last1, busy1, out_data1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({in_ready1, out_valid1, busy1, in_ready2, busy2} !== 5'b10010) begin
      n_bad++;
      $display("FAIL post_reset: rdy1=%b vld1=%b busy1=%b rdy2=%b busy2=%b, expected 1 0 0 1 0",
               in_ready1, out_valid1, busy1, in_ready2, busy2);
    end
  endtask

  task automatic test_basic();
    int exp_v [4] = '{5, 7, 13, 15};
    out_ready1 = 1'b1;
    send(1, ramp(0, 1));
    collect(1, 4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_v[i]) || got_last[i] !== (i == 3)) begin
        n_bad++;
        $display("FAIL basic_out[%0d]: data=%0d last=%b, expected %0d %b",
                 i, $signed(got_data[i]), got_last[i], exp_v[i], i == 3);
      end
    end
    n_cmp++;
    if (got_cyc[0] !== 4) begin
      n_bad++;
      $display("FAIL basic_latency: first out_valid at cycle %0d, expected 4", got_cyc[0]);
    end
    n_cmp++;
    if (got_cyc[1] - got_cyc[0] !== 5) begin
      n_bad++;
      $display("FAIL basic_period: %0d cycles between outputs, expected 5", got_cyc[1] - got_cyc[0]);
    end
    n_cmp++;
    if (in_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_ready_after: in_ready=%b, expected 1", in_ready1);
    end
  endtask

  task automatic test_signed();
    logic [32*DW-1:0] t;
    int e0;
`ifdef MAXPOOL_RELU_EN
    e0 = 0;
`else
    e0 = -1;
`endif
    t = '0;
    t[0*DW +: DW] = -3;
    t[1*DW +: DW] = -7;
    t[4*DW +: DW] = -1;
    t[5*DW +: DW] = -9;
    out_ready1 = 1'b1;
    send(1, t);
    collect(1, 4);
    n_cmp++;
    if (got_data[0] !== DW'(e0)) begin
      n_bad++;
      $display("FAIL signed_win0: got %0d, expected %0d", $signed(got_data[0]), e0);
    end
    n_cmp++;
    if (got_data[1] !== '0 || got_data[2] !== '0 || got_data[3] !== '0) begin
      n_bad++;
      $display("FAIL signed_zero_wins: got %0d %0d %0d, expected 0 0 0",
               $signed(got_data[1]), $signed(got_data[2]), $signed(got_data[3]));
    end
  endtask

  task automatic test_backpressure();
    int  w;
    bit  stable;
    int  exp_v [3] = '{7, 13, 15};
    out_ready1 = 1'b1;
    send(1, ramp(0, 1));
    w = 0;
    while (out_valid1 !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    n_cmp++;
    if (out_valid1 !== 1'b1 || out_data1 !== DW'(5)) begin
      n_bad++;
      $display("FAIL bp_first: valid=%b data=%0d, expected 1 5", out_valid1, $signed(out_data1));
    end
    @(negedge clk);
    out_ready1 = 1'b0;
    w = 0;
    while (out_valid1 !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid1 !== 1'b1 || out_data1 !== DW'(7)) stable = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL bp_hold: valid=%b data=%0d, expected 1 7 held for 10 cycles",
               out_valid1, $signed(out_data1));
    end
    out_ready1 = 1'b1;
    collect(1, 3);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_v[i]) || got_last[i] !== (i == 2)) begin
        n_bad++;
        $display("FAIL bp_out[%0d]: data=%0d last=%b, expected %0d %b",
                 i, $signed(got_data[i]), got_last[i], exp_v[i], i == 2);
      end
    end
  endtask

  task automatic test_busy_input();
    logic [32*DW-1:0] junk;
    bit rdy_low, busy_hi;
    int exp_v [4] = '{5, 7, 13, 15};
    junk = ramp(1000, 1);
    out_ready1 = 1'b0;
    send(1, ramp(0, 1));
    rdy_low = 1'b1;
    busy_hi = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid1 = (i % 2 == 0);
      tensor1   = junk[16*DW-1:0];
      if (in_ready1 !== 1'b0) rdy_low = 1'b0;
      if (busy1 !== 1'b1) busy_hi = 1'b0;
      @(negedge clk);
    end
    in_valid1 = 1'b0;
    n_cmp++;
    if (!rdy_low) begin
      n_bad++;
      $display("FAIL busy_in_ready: in_ready=%b seen while busy, expected 0", in_ready1);
    end
    n_cmp++;
    if (!busy_hi) begin
      n_bad++;
      $display("FAIL busy_flag: busy=%b during frame, expected 1", busy1);
    end
    out_ready1 = 1'b1;
    collect(1, 4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_v[i])) begin
        n_bad++;
        $display("FAIL busy_out[%0d]: got %0d, expected %0d", i, $signed(got_data[i]), exp_v[i]);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_no_extra: valid=%b ready=%b, expected 0 1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_mid_reset();
    int exp_v [4] = '{21, 23, 29, 31};
    out_ready1 = 1'b1;
    send(1, ramp(0, 1));
    collect(1, 2);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_abort: valid=%b busy=%b, expected 0 0", out_valid1, busy1);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_release: ready=%b valid=%b, expected 1 0", in_ready1, out_valid1);
    end
    send(1, ramp(16, 1));
    collect(1, 4);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_v[i]) || got_last[i] !== (i == 3)) begin
        n_bad++;
        $display("FAIL rst_next[%0d]: data=%0d last=%b, expected %0d %b",
                 i, $signed(got_data[i]), got_last[i], exp_v[i], i == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32*DW-1:0] a;
    int exp_a [8] = '{5, 7, 13, 15, 105, 107, 113, 115};
    int exp_b [8] = '{10, 14, 26, 30, 42, 46, 58, 62};
    a = ramp(0, 1);
    for (int i = 16; i < 32; i++) a[i*DW +: DW] = DW'(i - 16 + 100);
    out_ready2 = 1'b1;
    in_valid2  = 1'b1;
    tensor2    = a;
    @(negedge clk);
    tensor2 = ramp(0, 2);
    collect(2, 8);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_a[i]) || got_last[i] !== (i == 7)) begin
        n_bad++;
        $display("FAIL b2b_a[%0d]: data=%0d last=%b, expected %0d %b",
                 i, $signed(got_data[i]), got_last[i], exp_a[i], i == 7);
      end
    end
    n_cmp++;
    if (in_ready2 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_idle_gap: in_ready=%b, expected 1", in_ready2);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready2 !== 1'b0 || busy2 !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_recapture: ready=%b busy=%b, expected 0 1", in_ready2, busy2);
    end
    in_valid2 = 1'b0;
    collect(2, 8);
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got_data[i] !== DW'(exp_b[i]) || got_last[i] !== (i == 7)) begin
        n_bad++;
        $display("FAIL b2b_b[%0d]: data=%0d last=%b, expected %0d %b",
                 i, $signed(got_data[i]), got_last[i], exp_b[i], i == 7);
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid1  = 1'b0;
    in_valid2  = 1'b0;
    out_ready1 = 1'b0;
    out_ready2 = 1'b0;
    tensor1    = '0;
    tensor2    = '0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_backpressure();
    test_busy_input();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maxpool_stream.md
# maxpool_stream

Sequential max-pooling stage that sits directly downstream of the convolution forward pass. It accepts one complete flattened conv output tensor per valid/ready handshake. It scans each pooling window one element per cycle with a small FSM and streams the pooled results out one word at a time. Output order is channel-major, then row, then column, which matches the flattening used by the conv stage.

## Interface
- CHANNELS, 1: number of feature-map channels, equal to the conv stage's OUT_CHANNELS.
- IN_HEIGHT, 4: input feature-map height.
- IN_WIDTH, 4: input feature-map width.
- POOL_SIZE, 2: pooling window edge length P.
- POOL_STRIDE, 2: pooling stride S.
- DATA_WIDTH, 32: element width, signed two's complement.
- Derived localparams: OUT_H = (IN_HEIGHT-P)/S+1, OUT_W = (IN_WIDTH-P)/S+1, N_OUT = CHANNELS*OUT_H*OUT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_tensor_flat holds a valid tensor.
- in_ready  out  1  block can accept a tensor.
- in_tensor_flat  in  CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH  element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DATA_WIDTH  pooled value, signed.
- out_last  out  1  marks the final (N_OUT-th) output of the current tensor.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SCAN, EMIT.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, register the whole tensor internally, clear the channel/row/col counters and the element index k, load the running max with its init value, and go to SCAN.
- SCAN:
  - One element per cycle, k = 0 … P*P-1, with kh = k/P and kw = k%P.
  - Element address = ch*IN_HEIGHT*IN_WIDTH + (row*S+kh)*IN_WIDTH + (col*S+kw).
  - Running max updated with a signed comparison.
  - On k = P*P-1: register the max into out_data, set out_last if this is the final window, go to EMIT.
- EMIT:
  - out_valid = 1.
  - out_data and out_last are held stable until out_ready is seen high.
  - On handshake after the final window, go to IDLE.
  - On any other handshake, advance col, then row, then ch; reset k and the running max; go to SCAN.
- in_valid while busy is ignored, since in_ready is low. The captured tensor is never overwritten mid-frame.
- The input tensor is held only in the internal register. in_tensor_flat may change after the capture edge.
- Requires IN_HEIGHT ≥ P and IN_WIDTH ≥ P. There is no padding and no partial windows; leftover rows and columns are dropped.
- Reset mid-operation: the frame is aborted. The FSM returns to IDLE, all counters clear, and no further outputs are produced for that frame.

## Timing
- Reset values: in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, busy = 0.
- in_ready is decoded from the registered state only; it has no combinational path from in_valid.
- Capture at edge E0. out_valid first rises after edge E0+P*P, i.e. 4 cycles for P = 2.
- With out_ready held high, a new output appears every P*P+1 cycles.
- Downstream backpressure stalls the block in EMIT with no data loss.
- in_ready returns high in the cycle after the final out handshake, so back-to-back frames are separated by one IDLE cycle.
- Arithmetic: only signed comparison is performed. out_data width equals DATA_WIDTH, with no growth or saturation.

## Configuration
- MAXPOOL_RELU_EN defined: the running max is initialised to 0. This fuses ReLU, giving out = max(0, window max); all-negative windows output 0.
- MAXPOOL_RELU_EN undefined: the running max is initialised to the most negative value, -2^(DATA_WIDTH-1). The output is the true signed window max.

## Structure
- The shared package cnn_pkg holds the FSM state encoding (IDLE/SCAN/EMIT) and the out-dimension helper used for OUT_H/OUT_W. The conv stage reuses the same helper.
- One sub-module, pool_window_addr: the ch/row/col/k counters plus address generation. It exposes a step input, a flat element address, and last_elem and last_window flags.
- The top level holds the FSM, the tensor register, the comparator, and the output registers.

## Test plan
- Test 1, basic pooling: 1 channel, 4×4 input with values 0..15 row-major, out_ready = 1. Expect outputs 5, 7, 13, 15; out_last only on 15; first out_valid 4 cycles after capture.
- Test 2, signed comparison: window {-3, -7, -1, -9}, all other windows 0. Expect -1 for that window without MAXPOOL_RELU_EN, and 0 with it.
- Test 3, backpressure: hold out_ready = 0 for 10 cycles at the second output. Expect out_valid and out_data (7) stable throughout; the sequence completes unchanged.
- Test 4, busy input: toggle in_valid with new data during a frame. Expect in_ready = 0 and output values from the originally captured tensor only.
- Test 5, mid-frame reset: assert rst during SCAN of the third window. Expect out_valid = 0 and in_ready = 1 after release; the next frame pools correctly from its first window.
- Test 6, two channels back-to-back: CHANNELS = 2, second channel = first + 100. Expect 5, 7, 13, 15, 105, 107, 113, 115, then one IDLE cycle before the next capture.
